stage_execute: RTL and testbench



---
 rtl/cpu_common_pkg.sv | 52 +++++
 rtl/stage_execute_alu.sv | 25 ++
 rtl/stage_execute.sv | 98 +++++++++
 tb/tb_stage_execute.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_common_pkg.sv
// Shared pipeline types: data word, register address, ALU modes, control word and execute-stage state.
package cpu_common;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [REG_AW-1:0]  regaddr_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } alu_mode_t;

  typedef struct packed {
    alu_mode_t alu_mode;
    regaddr_t  rd;
    logic      rd_wr;
    logic      mem_rd;
  } control_word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } exec_state_t;

  function automatic logic is_shift_op(input alu_mode_t mode);
    return (mode == SLL) || (mode == SRL) || (mode == SRA);
  endfunction

  // One partial shift step; SRA keeps replicating the sign bit across steps.
  function automatic word_t shift_word(input alu_mode_t mode, input word_t value, input shamt_t amt);
    case (mode)
      SLL:     return value << amt;
      SRL:     return value >> amt;
      SRA:     return word_t'($signed(value) >>> amt);
      default: return value;
    endcase
  endfunction

endpackage

// File: rtl/stage_execute_alu.sv
// Combinational ALU for the single-cycle (non-shift) modes.
module alu
  import cpu_common::*;
(
  input  alu_mode_t i_mode,
  input  word_t     i_op1,
  input  word_t     i_op2,
  output word_t     o_result_c
);

  always_comb begin
    o_result_c = '0;
    case (i_mode)
      ADD:     o_result_c = i_op1 + i_op2;
      SUB:     o_result_c = i_op1 - i_op2;
      AND:     o_result_c = i_op1 & i_op2;
      OR:      o_result_c = i_op1 | i_op2;
      XOR:     o_result_c = i_op1 ^ i_op2;
      SLT:     o_result_c = ($signed(i_op1) < $signed(i_op2)) ? word_t'(1) : word_t'(0);
      SLTU:    o_result_c = (i_op1 < i_op2) ? word_t'(1) : word_t'(0);
      default: o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/stage_execute.sv
// Execute stage: ALU plus iterative shifter, one-entry result register with valid/ready
// toward memory, and a single bypass slot for the issue stage.
module stage_execute
  import cpu_common::*;
#(
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  control_word_t issue_cw_i,
  input  word_t         issue_alu_op1_i,
  input  word_t         issue_alu_op2_i,
  input  logic          issue_valid_i,
  output logic          issue_ready_o,
  output control_word_t exec_cw_o,
  output word_t         exec_result_o,
  output logic          exec_valid_o,
  input  logic          exec_ready_i,
  output regaddr_t      bypass_addr_o,
  output word_t         bypass_data_o,
  output logic          bypass_valid_o,
  output logic          bypass_ready_o
);

  localparam shamt_t STEP = SHAMT_W'(SHIFT_STEP);

  exec_state_t   r_state;
  control_word_t r_cw;
  word_t         r_result;
  shamt_t        r_remaining;

  word_t  w_alu_result;
  word_t  w_load_value;
  logic   w_accept;
  logic   w_start_shift;
  shamt_t w_shamt;
  shamt_t w_step;

  alu u_alu (
    .i_mode     (issue_cw_i.alu_mode),
    .i_op1      (issue_alu_op1_i),
    .i_op2      (issue_alu_op2_i),
    .o_result_c (w_alu_result)
  );

  assign issue_ready_o = (r_state == EMPTY) || ((r_state == FULL) && exec_ready_i);
  assign w_accept      = issue_valid_i && issue_ready_o;
  assign w_shamt       = issue_alu_op2_i[SHAMT_W-1:0];
  assign w_start_shift = is_shift_op(issue_cw_i.alu_mode) && (w_shamt != '0);
  // A zero-distance shift completes immediately with op1 unchanged.
  assign w_load_value  = is_shift_op(issue_cw_i.alu_mode) ? issue_alu_op1_i : w_alu_result;
  assign w_step        = (r_remaining > STEP) ? STEP : r_remaining;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_cw        <= '0;
      r_result    <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        EMPTY, FULL: begin
          if (w_accept) begin
            r_cw <= issue_cw_i;
            if (w_start_shift) begin
              r_result    <= issue_alu_op1_i;
              r_remaining <= w_shamt;
              r_state     <= SHIFT;
            end else begin
              r_result    <= w_load_value;
              r_remaining <= '0;
              r_state     <= FULL;
            end
          end else if ((r_state == FULL) && exec_ready_i) begin
            r_state <= EMPTY;
          end
        end
        SHIFT: begin
          // Final partial step lands in the same cycle as the move to FULL.
          r_result    <= shift_word(r_cw.alu_mode, r_result, w_step);
          r_remaining <= r_remaining - w_step;
          if (r_remaining <= STEP) r_state <= FULL;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign exec_cw_o      = r_cw;
  assign exec_result_o  = r_result;
  assign exec_valid_o   = (r_state == FULL);
  assign bypass_addr_o  = r_cw.rd;
  assign bypass_data_o  = r_result;
  assign bypass_valid_o = (r_state != EMPTY) && r_cw.rd_wr && (r_cw.rd != '0);
  // A load's ALU result is an address, so it is never forwarded as register data.
  assign bypass_ready_o = bypass_valid_o && (r_state == FULL) && !r_cw.mem_rd;

endmodule

// File: tb/tb_stage_execute.sv
// Scoreboard bench for stage_execute: directed scenarios followed by randomized traffic.
module tb_stage_execute;
  import cpu_common::*;

  localparam int unsigned STEP = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  control_word_t issue_cw_i;
  word_t         issue_alu_op1_i;
  word_t         issue_alu_op2_i;
  logic          issue_valid_i;
  logic          issue_ready_o;
  control_word_t exec_cw_o;
  word_t         exec_result_o;
  logic          exec_valid_o;
  logic          exec_ready_i;
  regaddr_t      bypass_addr_o;
  word_t         bypass_data_o;
  logic          bypass_valid_o;
  logic          bypass_ready_o;

  stage_execute #(.SHIFT_STEP(STEP)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .issue_cw_i      (issue_cw_i),
    .issue_alu_op1_i (issue_alu_op1_i),
    .issue_alu_op2_i (issue_alu_op2_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .exec_cw_o       (exec_cw_o),
    .exec_result_o   (exec_result_o),
    .exec_valid_o    (exec_valid_o),
    .exec_ready_i    (exec_ready_i),
    .bypass_addr_o   (bypass_addr_o),
    .bypass_data_o   (bypass_data_o),
    .bypass_valid_o  (bypass_valid_o),
    .bypass_ready_o  (bypass_ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    control_word_t cw;
    word_t         res;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  logic rnd_ready_en = 1'b0;

  // Reference semantics straight from the ALU mode definitions.
  function automatic word_t ref_alu(input alu_mode_t m, input word_t a, input word_t b);
    logic [4:0] sh;
    sh = b[4:0];
    case (m)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      SLL:     return a << sh;
      SRL:     return a >> sh;
      SRA:     return 32'($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic control_word_t mk_cw(input alu_mode_t m, input int rd, input bit wr, input bit mr);
    control_word_t c;
    c.alu_mode = m;
    c.rd       = 5'(rd);
    c.rd_wr    = wr;
    c.mem_rd   = mr;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and hold it until accepted; waited = cycles until accept.
  task automatic issue(input control_word_t cw, input word_t a, input word_t b, output int waited);
    issue_cw_i      = cw;
    issue_alu_op1_i = a;
    issue_alu_op2_i = b;
    issue_valid_i   = 1'b1;
    waited          = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (issue_ready_o) begin
        waited = k;
        break;
      end
    end
    if (waited == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: issue_ready_o stayed 0 for 64 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
    issue_valid_i = 1'b0;
  endtask

  // Stimulus side of the scoreboard: record the expected result of every accept.
  always @(negedge clk) begin
    if (!rst_i && issue_valid_i && issue_ready_o) begin
      exp_t e;
      e.cw  = issue_cw_i;
      e.res = ref_alu(issue_cw_i.alu_mode, issue_alu_op1_i, issue_alu_op2_i);
      q.push_back(e);
    end
  end

  // Monitor: compare the held result against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_i && exec_valid_o) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: exec_valid_o=1 with result 0x%08h, expected no result", exec_result_o);
      end else begin
        check("sb_result", exec_result_o, q[0].res);
        check("sb_cw", 32'(exec_cw_o), 32'(q[0].cw));
        check("sb_byp_valid", 32'(bypass_valid_o), 32'(q[0].cw.rd_wr && (q[0].cw.rd != 5'd0)));
        check("sb_byp_ready", 32'(bypass_ready_o),
              32'(q[0].cw.rd_wr && (q[0].cw.rd != 5'd0) && !q[0].cw.mem_rd));
        check("sb_byp_addr", 32'(bypass_addr_o), 32'(q[0].cw.rd));
        check("sb_byp_data", bypass_data_o, q[0].res);
        if (exec_ready_i) begin
          void'(q.pop_front());
          n_pop++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready_en) begin
      #1;
      exec_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cnt;
    int p0;
    word_t s_op1 [8];
    word_t s_op2 [8];
    alu_mode_t s_mode [8];

    rst_i           = 1'b1;
    issue_valid_i   = 1'b0;
    issue_cw_i      = '0;
    issue_alu_op1_i = '0;
    issue_alu_op2_i = '0;
    exec_ready_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    tick();

    check("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    check("rst_exec_valid", 32'(exec_valid_o), 32'd0);
    check("rst_result", exec_result_o, 32'd0);
    check("rst_cw", 32'(exec_cw_o), 32'd0);
    check("rst_byp_valid", 32'(bypass_valid_o), 32'd0);
    check("rst_byp_ready", 32'(bypass_ready_o), 32'd0);
    check("rst_byp_addr", 32'(bypass_addr_o), 32'd0);
    check("rst_byp_data", bypass_data_o, 32'd0);

    // ADD overflow, then back-pressure for 5 cycles.
    issue(mk_cw(ADD, 5, 1'b1, 1'b0), 32'h7FFF_FFFF, 32'd1, w);
    check("add_valid", 32'(exec_valid_o), 32'd1);
    check("add_result", exec_result_o, 32'h8000_0000);
    check("add_byp_valid", 32'(bypass_valid_o), 32'd1);
    check("add_byp_ready", 32'(bypass_ready_o), 32'd1);
    check("add_byp_data", bypass_data_o, 32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      check("bp_issue_ready", 32'(issue_ready_o), 32'd0);
      check("bp_valid", 32'(exec_valid_o), 32'd1);
      check("bp_result", exec_result_o, 32'h8000_0000);
      check("bp_byp_addr", 32'(bypass_addr_o), 32'd5);
      tick();
    end
    exec_ready_i = 1'b1;
    issue(mk_cw(SUB, 6, 1'b1, 1'b0), 32'd5, 32'd7, w);
    check("bp_release_same_cycle", 32'(w), 32'd1);
    check("bp_sub_result", exec_result_o, 32'hFFFF_FFFE);
    tick();

    // Load address is not forwardable; rd=0 never claims a bypass.
    exec_ready_i = 1'b0;
    issue(mk_cw(ADD, 3, 1'b1, 1'b1), 32'd100, 32'd4, w);
    check("load_byp_valid", 32'(bypass_valid_o), 32'd1);
    check("load_byp_ready", 32'(bypass_ready_o), 32'd0);
    check("load_byp_addr", 32'(bypass_addr_o), 32'd3);
    exec_ready_i = 1'b1;
    tick();
    exec_ready_i = 1'b0;
    issue(mk_cw(XOR, 0, 1'b1, 1'b0), 32'h1234_5678, 32'hFFFF_0000, w);
    check("rd0_byp_valid", 32'(bypass_valid_o), 32'd0);
    check("rd0_byp_ready", 32'(bypass_ready_o), 32'd0);
    exec_ready_i = 1'b1;
    tick();

    // Iterative SRA by 31: busy for ceil(31/STEP) cycles with a partial bypass.
    issue(mk_cw(SRA, 9, 1'b1, 1'b0), 32'h8000_0000, 32'hFFFF_FFFF, w);
    cnt = 0;
    while (!exec_valid_o && cnt < 40) begin
      check("sra_issue_ready", 32'(issue_ready_o), 32'd0);
      check("sra_byp_valid", 32'(bypass_valid_o), 32'd1);
      check("sra_byp_ready", 32'(bypass_ready_o), 32'd0);
      tick();
      cnt++;
    end
    check("sra_latency", 32'(cnt), 32'((31 + STEP - 1) / STEP));
    check("sra_result", exec_result_o, 32'hFFFF_FFFF);
    check("sra_byp_ready_final", 32'(bypass_ready_o), 32'd1);
    tick();

    // Back-to-back stream: one accept per cycle.
    s_mode = '{ADD, SUB, SLT, SLTU, ADD, SUB, SLT, SLTU};
    s_op1  = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom};
    s_op2  = '{32'd4, 32'd4, 32'd1, 32'd1, $urandom, $urandom, $urandom, $urandom};
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      issue(mk_cw(s_mode[i], i + 1, 1'b1, 1'b0), s_op1[i], s_op2[i], w);
      check("stream_one_per_cycle", 32'(w), 32'd1);
      if (i == 2) check("stream_slt", exec_result_o, 32'd1);
      if (i == 3) check("stream_sltu", exec_result_o, 32'd0);
    end
    tick();
    check("stream_pops", 32'(n_pop - p0), 32'd8);

    // Asynchronous reset while a shift is iterating.
    p0 = n_pop;
    issue(mk_cw(SLL, 7, 1'b1, 1'b0), 32'd1, 32'd20, w);
    tick();
    rst_i = 1'b1;
    #1;
    check("arst_exec_valid", 32'(exec_valid_o), 32'd0);
    check("arst_issue_ready", 32'(issue_ready_o), 32'd1);
    check("arst_byp_valid", 32'(bypass_valid_o), 32'd0);
    check("arst_byp_ready", 32'(bypass_ready_o), 32'd0);
    check("arst_result", exec_result_o, 32'd0);
    check("arst_cw", 32'(exec_cw_o), 32'd0);
    check("arst_byp_addr", 32'(bypass_addr_o), 32'd0);
    q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    tick();
    check("arst_no_handshake", 32'(n_pop - p0), 32'd0);
    check("arst_still_empty", 32'(exec_valid_o), 32'd0);

    // Randomized traffic with random back-pressure and issue gaps.
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      control_word_t c;
      c.alu_mode = alu_mode_t'(4'($urandom_range(0, 9)));
      c.rd       = 5'($urandom);
      c.rd_wr    = 1'($urandom);
      c.mem_rd   = 1'($urandom);
      issue(c, $urandom, $urandom, w);
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_ready_en = 1'b0;
    tick();
    tick();
    exec_ready_i = 1'b1;
    cnt = 0;
    while (q.size() != 0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    check("drain_idle", 32'(exec_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
